// File: rtl/dmem_arb_pkg.sv
// Shared types and default sizing for the data-memory port arbiter.
// The owner enum records which requester held the previous grant.
package dmem_arb_pkg;

    localparam int ADDR_W_DEF         = 8;
    localparam int DATA_W_DEF         = 8;
    localparam int HOST_BURST_MAX_DEF = 4;
    localparam int CPU_RUN_MAX_DEF    = 8;

    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_HOST = 2'd2
    } owner_e;

endpackage

// File: rtl/arb_sat_counter.sv
// Saturating run-length counter: counts up to MAX and holds there.
// Clear wins over increment.
module arb_sat_counter #(
    parameter int MAX = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         inc,
    input  logic                         clr,
    output logic                         at_max,
    output logic [$clog2(MAX+1)-1:0]     count
);

    localparam int W = $clog2(MAX + 1);
    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (inc && (count_reg != MAX_V)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign at_max = (count_reg == MAX_V);
    assign count  = count_reg;

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single-port data memory between the execute stage (CPU) and a host port,
// with bounded-latency fairness in both directions and a stall output to the pipeline.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int DATA_W         = DATA_W_DEF,
    parameter int HOST_BURST_MAX = HOST_BURST_MAX_DEF,
    parameter int CPU_RUN_MAX    = CPU_RUN_MAX_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int HRW = $clog2(HOST_BURST_MAX + 1);
    localparam int CRW = $clog2(CPU_RUN_MAX + 1);
    localparam logic [HRW-1:0] HOST_MAX_V = HRW'(HOST_BURST_MAX);

    owner_e            state_reg, state_next;
    logic              cpu_grant, host_grant;
    logic              host_at_max, cpu_at_max;
    logic [HRW-1:0]    host_run;
    logic [CRW-1:0]    cpu_run;
    logic              cpu_run_unused;
    logic [ADDR_W-1:0] addr_hold_reg;
    logic [DATA_W-1:0] wdata_hold_reg;
    logic              cpu_rvalid_reg, host_rvalid_reg;
    logic [DATA_W-1:0] cpu_rdata_reg, host_rdata_reg;

    // Host run clears on any cycle the host is not granted (including a mid-burst drop).
    arb_sat_counter #(.MAX(HOST_BURST_MAX)) u_host_run (
        .clk    (clk),
        .reset  (reset),
        .inc    (host_grant),
        .clr    (~host_grant),
        .at_max (host_at_max),
        .count  (host_run)
    );

    // CPU run only accumulates while the host is actually waiting.
    arb_sat_counter #(.MAX(CPU_RUN_MAX)) u_cpu_run (
        .clk    (clk),
        .reset  (reset),
        .inc    (cpu_grant & host_req),
        .clr    (~(cpu_grant & host_req)),
        .at_max (cpu_at_max),
        .count  (cpu_run)
    );

    assign cpu_run_unused = ^cpu_run;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= OWN_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = OWN_IDLE;
        if (host_grant) begin
            state_next = OWN_HOST;
        end else if (cpu_grant) begin
            state_next = OWN_CPU;
        end
    end

    // Grants are suppressed during reset so nothing issued in that cycle has any effect.
    always_comb begin
        cpu_grant  = 1'b0;
        host_grant = 1'b0;
        if (!reset) begin
            if (cpu_req && host_req) begin
                if (host_at_max) begin
                    cpu_grant = 1'b1;
                end else if (cpu_at_max) begin
                    host_grant = 1'b1;
                end else if ((state_reg == OWN_HOST) && (host_run < HOST_MAX_V)) begin
                    host_grant = 1'b1;
                end else begin
                    cpu_grant = 1'b1;
                end
            end else begin
                cpu_grant  = cpu_req;
                host_grant = host_req;
            end
        end
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = addr_hold_reg;
        mem_wdata = wdata_hold_reg;
        if (host_grant) begin
            mem_we    = host_we;
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
        end else if (cpu_grant) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end
    end

    assign cpu_stall = cpu_req & ~cpu_grant;
    assign host_gnt  = host_grant;

    // Idle cycles replay the last granted address/data so the memory inputs stay quiet.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_hold_reg  <= '0;
            wdata_hold_reg <= '0;
        end else if (cpu_grant || host_grant) begin
            addr_hold_reg  <= mem_addr;
            wdata_hold_reg <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_rvalid_reg  <= 1'b0;
            host_rvalid_reg <= 1'b0;
            cpu_rdata_reg   <= '0;
            host_rdata_reg  <= '0;
        end else begin
            cpu_rvalid_reg  <= cpu_grant & ~cpu_we;
            host_rvalid_reg <= host_grant & ~host_we;
            if (cpu_grant && !cpu_we) begin
                cpu_rdata_reg <= mem_rdata;
            end
            if (host_grant && !host_we) begin
                host_rdata_reg <= mem_rdata;
            end
        end
    end

    assign cpu_rvalid  = cpu_rvalid_reg;
    assign host_rvalid = host_rvalid_reg;
    assign cpu_rdata   = cpu_rdata_reg;
    assign host_rdata  = host_rdata_reg;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a run-length model of the arbiter.
module tb_dmem_port_arbiter;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int HB = 4;
    localparam int CR = 8;

    logic          clk        = 1'b0;
    logic          reset      = 1'b1;
    logic          cpu_req    = 1'b0;
    logic          cpu_we     = 1'b0;
    logic [AW-1:0] cpu_addr   = '0;
    logic [DW-1:0] cpu_wdata  = '0;
    logic          host_req   = 1'b0;
    logic          host_we    = 1'b0;
    logic [AW-1:0] host_addr  = '0;
    logic [DW-1:0] host_wdata = '0;
    logic          cpu_stall, cpu_rvalid, host_gnt, host_rvalid, mem_we;
    logic [DW-1:0] cpu_rdata, host_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;

    logic [DW-1:0] mem     [0:255];
    logic [DW-1:0] ref_mem [0:255];

    int n_checks = 0;
    int n_pass   = 0;

    int cpu_pct  [6] = '{90, 50, 95, 20, 100, 70};
    int host_pct [6] = '{90, 95, 50, 100, 100, 30};

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_we) mem[mem_addr] = mem_wdata;

    dmem_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .HOST_BURST_MAX(HB), .CPU_RUN_MAX(CR)
    ) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model state: who owned the last grant and how long the current runs are.
    bit            m_live      = 1'b0;
    int            last_owner  = 0;
    int            host_streak = 0;
    int            cpu_streak  = 0;
    int            cpu_wait    = 0;
    int            host_wait   = 0;
    bit            exp_cpu_rv  = 1'b0;
    bit            exp_host_rv = 1'b0;
    logic [DW-1:0] exp_cpu_rd  = '0;
    logic [DW-1:0] exp_host_rd = '0;
    logic [DW-1:0] hold_wdata  = '0;
    logic [AW-1:0] hold_addr   = '0;

    always @(negedge clk) begin : model
        int            who;
        logic          exp_we;
        logic [AW-1:0] ea;
        logic [DW-1:0] ew;
        if (m_live) begin
            check("cpu_rvalid", cpu_rvalid, exp_cpu_rv);
            check("host_rvalid", host_rvalid, exp_host_rv);
            check("cpu_rdata", cpu_rdata, exp_cpu_rd);
            check("host_rdata", host_rdata, exp_host_rd);
        end
        if (reset) begin
            if (m_live) check("mem_we_in_reset", mem_we, 0);
            m_live = 1'b1;
            last_owner = 0; host_streak = 0; cpu_streak = 0;
            cpu_wait = 0; host_wait = 0;
            exp_cpu_rv = 1'b0; exp_host_rv = 1'b0;
            exp_cpu_rd = '0; exp_host_rd = '0;
            hold_addr = '0; hold_wdata = '0;
        end else if (m_live) begin
            who = 0;
            if (cpu_req && host_req) begin
                if (host_streak >= HB)      who = 1;
                else if (cpu_streak >= CR)  who = 2;
                else if (last_owner == 2)   who = 2;
                else                        who = 1;
            end else if (cpu_req) begin
                who = 1;
            end else if (host_req) begin
                who = 2;
            end
            exp_we = (who == 1) ? cpu_we : (who == 2) ? host_we : 1'b0;
            ea = (who == 1) ? cpu_addr : (who == 2) ? host_addr : hold_addr;
            ew = (who == 1) ? cpu_wdata : (who == 2) ? host_wdata : hold_wdata;
            check("cpu_stall", cpu_stall, cpu_req && (who != 1));
            check("host_gnt", host_gnt, who == 2);
            check("mem_we", mem_we, exp_we);
            check("mem_addr", mem_addr, ea);
            check("mem_wdata", mem_wdata, ew);

            exp_cpu_rv  = (who == 1) && !cpu_we;
            exp_host_rv = (who == 2) && !host_we;
            if (exp_cpu_rv)  exp_cpu_rd  = ref_mem[ea];
            if (exp_host_rv) exp_host_rd = ref_mem[ea];
            if (exp_we) ref_mem[ea] = ew;
            hold_addr  = ea;
            hold_wdata = ew;

            if (who == 2) begin
                host_streak++; cpu_streak = 0;
            end else if (who == 1) begin
                cpu_streak = host_req ? cpu_streak + 1 : 0; host_streak = 0;
            end else begin
                cpu_streak = 0; host_streak = 0;
            end
            last_owner = who;

            cpu_wait  = (cpu_req && cpu_stall) ? cpu_wait + 1 : 0;
            host_wait = (host_req && !host_gnt) ? host_wait + 1 : 0;
            if (cpu_wait > 0)  check("cpu_wait_bound", cpu_wait <= HB, 1);
            if (host_wait > 0) check("host_wait_bound", host_wait <= CR, 1);
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        cpu_req = 1'b0; host_req = 1'b0; cpu_we = 1'b0; host_we = 1'b0;
    endtask

    // Each cycle c: host issues item hi (advances on grant), CPU reads 0x10.
    task automatic run_table(input string tag, input int n, input logic [15:0] hreq,
                             input logic [15:0] creq, input logic [15:0] eh,
                             input logic [15:0] es, input bit hwe, input logic [7:0] hbase);
        int hi = 0;
        for (int c = 0; c < n; c++) begin
            next_cycle();
            host_req = hreq[c]; host_we = hwe;
            host_addr = hbase + 8'(hi); host_wdata = 8'(hi + 1);
            cpu_req = creq[c]; cpu_we = 1'b0; cpu_addr = 8'h10; cpu_wdata = 8'h00;
            @(negedge clk);
            $display("%s c%0d host_gnt=%0b cpu_stall=%0b mem_addr=%02h", tag, c, host_gnt, cpu_stall, mem_addr);
            check({tag, "_host_gnt"}, host_gnt, eh[c]);
            check({tag, "_cpu_stall"}, cpu_stall, es[c]);
            if (host_gnt) hi++;
        end
        next_cycle();
        go_idle();
        @(negedge clk);
    endtask

    initial begin
        bit cpu_hold;
        bit host_hold;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[8'h10] = 8'hA5;
        mem[8'h30] = 8'h3C;
        for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];

        next_cycle();
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        check("rst_cpu_rvalid", cpu_rvalid, 0);
        check("rst_host_rvalid", host_rvalid, 0);
        check("rst_cpu_rdata", cpu_rdata, 0);
        check("rst_host_rdata", host_rdata, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_we", mem_we, 0);

        // CPU-only read of 0x10
        next_cycle();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
        @(negedge clk);
        $display("cpu_read addr=%02h stall=%0b", mem_addr, cpu_stall);
        check("cpu_only_stall", cpu_stall, 0);
        check("cpu_only_addr", mem_addr, 8'h10);
        next_cycle();
        go_idle();
        @(negedge clk);
        $display("cpu_read return rvalid=%0b rdata=%02h", cpu_rvalid, cpu_rdata);
        check("cpu_only_rvalid", cpu_rvalid, 1);
        check("cpu_only_rdata", cpu_rdata, 8'hA5);
        check("cpu_only_host_rvalid", host_rvalid, 0);

        // Both from idle: CPU wins 8 times, host gets the 9th cycle
        run_table("simul", 9, 16'h01FF, 16'h01FF, 16'h0100, 16'h0100, 1'b0, 8'h12);
        // Host write burst of 6, CPU asks from 2nd host cycle for one access
        run_table("burst", 7, 16'h007F, 16'h001E, 16'h006F, 16'h000E, 1'b1, 8'h20);
        for (int i = 0; i < 6; i++) check("burst_mem", mem[8'h20 + 8'(i)], 8'(i + 1));
        // Host drops after 2 grants; later full burst proves the run restarted
        run_table("drop", 8, 16'h00FB, 16'h00F6, 16'h007B, 16'h0072, 1'b0, 8'h40);

        // Reset in the cycle the host writes 0xFF to 0x30
        next_cycle();
        host_req = 1'b1; host_we = 1'b1; host_addr = 8'h31; host_wdata = 8'h77;
        @(negedge clk);
        next_cycle();
        reset = 1'b1; host_addr = 8'h30; host_wdata = 8'hFF;
        @(negedge clk);
        $display("reset_write mem_we=%0b", mem_we);
        check("rst_write_mem_we", mem_we, 0);
        next_cycle();
        reset = 1'b0;
        host_we = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
        @(negedge clk);
        check("rst_after_host_gnt", host_gnt, 0);
        check("rst_after_cpu_stall", cpu_stall, 0);
        check("rst_after_cpu_rvalid", cpu_rvalid, 0);
        check("rst_after_host_rvalid", host_rvalid, 0);
        check("rst_mem30_unchanged", mem[8'h30], 8'h3C);
        next_cycle();
        go_idle();
        @(negedge clk);
        check("rst_after_cpu_rdata", cpu_rdata, 8'hA5);

        // Idle for 5 cycles
        for (int k = 0; k < 5; k++) begin
            next_cycle();
            @(negedge clk);
            $display("idle c%0d mem_addr=%02h mem_we=%0b", k, mem_addr, mem_we);
            check("idle_mem_we", mem_we, 0);
            check("idle_mem_addr", mem_addr, 8'h10);
            check("idle_rvalid", {cpu_rvalid, host_rvalid}, 0);
        end

        // Randomized traffic; a stalled CPU keeps its request stable
        cpu_hold = 1'b0;
        host_hold = 1'b0;
        for (int ph = 0; ph < 6; ph++) begin
            for (int k = 0; k < 500; k++) begin
                next_cycle();
                reset = ($urandom_range(0, 299) == 0);
                if (!cpu_hold) begin
                    cpu_req   = ($urandom_range(0, 99) < cpu_pct[ph]);
                    cpu_we    = 1'($urandom_range(0, 1));
                    cpu_addr  = 8'h80 + 8'($urandom_range(0, 15));
                    cpu_wdata = 8'($urandom);
                end
                if (!host_hold) begin
                    host_req   = ($urandom_range(0, 99) < host_pct[ph]);
                    host_we    = 1'($urandom_range(0, 1));
                    host_addr  = 8'h80 + 8'($urandom_range(0, 15));
                    host_wdata = 8'($urandom);
                end
                @(negedge clk);
                cpu_hold  = cpu_req && cpu_stall;
                host_hold = host_req && !host_gnt && ($urandom_range(0, 3) != 0);
            end
            $display("random phase %0d done checks=%0d", ph, n_checks);
        end
        next_cycle();
        reset = 1'b0;
        go_idle();
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
Shares the single-port data memory between two requesters: the pipeline execute stage (CPU) and an external host/loader port used for data preload and inspection.
- Sits between the execute-stage memory signals and the data memory.
- Asserts a stall to the pipeline whenever the CPU is denied a cycle.
- Enforces bounded-latency fairness in both directions.

Parameters:
ADDR_W, 8, address width of data memory
DATA_W, 8, data width of data memory
HOST_BURST_MAX, 4, maximum consecutive host grants while CPU is waiting
CPU_RUN_MAX, 8, maximum consecutive CPU grants while host is waiting

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
cpu_req  in  1  execute stage requests memory access this cycle
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_stall  out  1  CPU request not granted this cycle; pipeline holds
cpu_rvalid  out  1  one-cycle pulse, cpu_rdata valid
cpu_rdata  out  DATA_W  registered read data for CPU
host_req  in  1  host requests access
host_we  in  1  host write enable
host_addr  in  ADDR_W  host address
host_wdata  in  DATA_W  host write data
host_gnt  out  1  host access performed this cycle
host_rvalid  out  1  one-cycle pulse, host_rdata valid
host_rdata  out  DATA_W  registered read data for host
mem_addr  out  ADDR_W  to data memory address
mem_we  out  1  to data memory write enable
mem_wdata  out  DATA_W  to data memory write data
mem_rdata  in  DATA_W  from data memory, combinational read of mem_addr

Behaviour:
- One clock. Reset is synchronous and active-high on `reset`. All state updates on the rising edge of `clk`.
- Owner state, registered: `OWN_IDLE`, `OWN_CPU`, `OWN_HOST`. It records the owner of the previous grant.
- Counters: `host_run` (0..HOST_BURST_MAX) and `cpu_run` (0..CPU_RUN_MAX), both saturating.
- Per-cycle grant decision is combinational from the requests, the state and the counters:
  - Only one requester active: that requester is granted.
  - Both active, default: CPU is granted.
  - Both active and state `OWN_HOST` with `host_run` < HOST_BURST_MAX: host keeps the grant (burst continuation).
  - Both active and `cpu_run` == CPU_RUN_MAX: host is granted (CPU starvation guard for the host).
  - Both active and `host_run` == HOST_BURST_MAX: CPU is granted; this has priority over burst continuation.
  - Neither active: no grant; `mem_we`=0; `mem_addr`/`mem_wdata` hold their last values.
- Outputs:
  - `cpu_stall` = `cpu_req` & ~cpu_grant, combinational.
  - `host_gnt` = host grant, combinational.
- Memory port: `mem_addr`/`mem_we`/`mem_wdata` are muxed combinationally from the granted requester. `mem_we` is forced 0 while `reset`=1 or when there is no grant.
- Counter updates:
  - Host grant: `host_run` += 1 (saturating). `cpu_run` = 0. State → `OWN_HOST`.
  - CPU grant: `cpu_run` += 1 only if `host_req`=1, else `cpu_run` = 0. `host_run` = 0. State → `OWN_CPU`.
  - No grant: both counters = 0. State → `OWN_IDLE`.
- Read return:
  - On a granted read, `mem_rdata` is registered into `cpu_rdata` or `host_rdata`.
  - The matching `rvalid` pulses for exactly one cycle on the next cycle (latency 1).
  - The non-granted requester's `rdata` holds its previous value.
  - Writes produce no `rvalid`.
- Stalled CPU: the pipeline keeps `cpu_req`/`cpu_we`/`cpu_addr`/`cpu_wdata` stable until `cpu_stall`=0. The arbiter does not latch CPU requests.
- `host_req` dropping mid-burst: the grant goes to the CPU in that same cycle if requested. `host_run` clears.
- Reset values:
  - state `OWN_IDLE`; `host_run`=0; `cpu_run`=0.
  - `cpu_rvalid`=0, `host_rvalid`=0, `cpu_rdata`=0, `host_rdata`=0.
  - Registered `mem_addr`/`mem_wdata` hold values = 0.
- Reset mid-operation: a grant in the reset cycle is discarded, with no write and no `rvalid` the next cycle. Arbitration restarts from `OWN_IDLE`.
- Worst-case wait:
  - CPU: ≤ HOST_BURST_MAX cycles.
  - Host: ≤ CPU_RUN_MAX cycles.

Decomposition:
- Package `dmem_arb_pkg`:
  - owner enum (`OWN_IDLE`, `OWN_CPU`, `OWN_HOST`).
  - default ADDR_W/DATA_W/HOST_BURST_MAX/CPU_RUN_MAX constants.
- One sub-module `arb_sat_counter` (parameter MAX; ports clk, reset, inc, clr, at_max, count), instantiated twice for `host_run` and `cpu_run`.
- Grant logic, muxing and read-return registers stay in the top module.

Test Plan:
- CPU only: CPU read addr 0x10 with mem[0x10]=0xA5 → `cpu_stall`=0, `mem_addr`=0x10, next cycle `cpu_rvalid`=1 and `cpu_rdata`=0xA5, `host_rvalid`=0.
- Simultaneous first request: `cpu_req` and `host_req` both asserted from `OWN_IDLE` → CPU granted, `host_gnt`=0. Host granted only after the CPU drops or after 8 consecutive CPU grants (cycle 9).
- Host burst: host writes 0x01..0x06 to addrs 0x20..0x25 while CPU requests from the 2nd host cycle → host gets 4 consecutive grants, then CPU gets 1 cycle with `cpu_stall`=0, then the host resumes. mem[0x20..0x25] = 0x01..0x06.
- Host drop mid-burst: `host_req` deasserted after 2 grants while CPU waiting → CPU granted the same cycle, `host_run` cleared.
- Reset mid-write: `reset`=1 in the cycle the host writes 0xFF to 0x30 → `mem_we`=0, mem[0x30] unchanged, all `rvalid`=0 the next cycle, state `OWN_IDLE`.
- Idle: no requests for 5 cycles → `mem_we`=0, `mem_addr` stable, counters 0, no `rvalid` pulses.
